// File: rtl/mempool_group_link.sv
// mempool_group_link: inter-group TCDM link fabric for the MemPool cluster.
// Direction d = k+1 from group g reaches group g^d. Every link owns an elastic
// FIFO on the request path and another on the response path.
//
// Ports ([NumGroups][NumDirs][NumTilesPerGroup] unless noted):
//   clk_i, rst_i        clock, synchronous active-high reset
//   mst_req_*           requests entering from group g, direction k
//   slv_req_*           requests delivered to group g's slave port k
//   slv_resp_*          responses entering from group g's slave port k
//   mst_resp_*          responses returned to group g, direction k
//   perf_clr_i          clears all stall counters
//   stall_cnt_o         [NumGroups][NumDirs] x 32 stall-cycle counters
//
// Optional feature: define MEMPOOL_LINK_PERF_EN to build the stall counters;
// otherwise stall_cnt_o is tied to zero and perf_clr_i is ignored.

package mempool_group_link_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  tgt_id;
  } tcdm_slave_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [5:0]  tgt_id;
  } tcdm_master_resp_t;

endpackage

// Ring-buffer FIFO, Depth >= 1. Ready depends only on occupancy, so there is
// no combinational path from out_ready or in_valid to in_ready.
module mempool_group_link_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  T     in_data,
  input  logic in_valid,
  output logic in_ready,
  output T     out_data,
  output logic out_valid,
  input  logic out_ready
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push;
  logic            pop;

  assign in_ready  = (cnt_q != CntW'(Depth));
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Payload storage, written only on push
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= in_data;
  end

endmodule

module mempool_group_link #(
  parameter int unsigned NumGroups        = 4,
  parameter int unsigned NumTilesPerGroup = 16,
  parameter int unsigned ReqDepth         = 2,
  parameter int unsigned RespDepth        = 2,
  parameter type         req_t            = mempool_group_link_pkg::tcdm_slave_req_t,
  parameter type         resp_t           = mempool_group_link_pkg::tcdm_master_resp_t,
  localparam int unsigned NumDirs         = NumGroups - 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  req_t        mst_req_i        [NumGroups][NumDirs][NumTilesPerGroup],
  input  logic        mst_req_valid_i  [NumGroups][NumDirs][NumTilesPerGroup],
  output logic        mst_req_ready_o  [NumGroups][NumDirs][NumTilesPerGroup],
  output resp_t       mst_resp_o       [NumGroups][NumDirs][NumTilesPerGroup],
  output logic        mst_resp_valid_o [NumGroups][NumDirs][NumTilesPerGroup],
  input  logic        mst_resp_ready_i [NumGroups][NumDirs][NumTilesPerGroup],
  output req_t        slv_req_o        [NumGroups][NumDirs][NumTilesPerGroup],
  output logic        slv_req_valid_o  [NumGroups][NumDirs][NumTilesPerGroup],
  input  logic        slv_req_ready_i  [NumGroups][NumDirs][NumTilesPerGroup],
  input  resp_t       slv_resp_i       [NumGroups][NumDirs][NumTilesPerGroup],
  input  logic        slv_resp_valid_i [NumGroups][NumDirs][NumTilesPerGroup],
  output logic        slv_resp_ready_o [NumGroups][NumDirs][NumTilesPerGroup],
  input  logic        perf_clr_i,
  output logic [31:0] stall_cnt_o      [NumGroups][NumDirs]
);

  // Elaboration-time parameter checks
  if (NumGroups < 2 || (NumGroups & (NumGroups - 1)) != 0) begin : gen_bad_groups
    $fatal(1, "mempool_group_link: NumGroups must be a power of two >= 2");
  end
  if (ReqDepth > 16 || RespDepth > 16) begin : gen_bad_depth
    $fatal(1, "mempool_group_link: ReqDepth/RespDepth must be <= 16");
  end

  // One request link and one response link per (group, direction, tile).
  // XOR routing is an involution, so every output element has exactly one driver.
  for (genvar g = 0; g < NumGroups; g++) begin : gen_grp
    for (genvar k = 0; k < NumDirs; k++) begin : gen_dir
      localparam int unsigned Dst = g ^ (k + 1);
      for (genvar t = 0; t < NumTilesPerGroup; t++) begin : gen_tile

        if (ReqDepth == 0) begin : gen_req_wire
          assign slv_req_o[Dst][k][t]       = mst_req_i[g][k][t];
          assign slv_req_valid_o[Dst][k][t] = mst_req_valid_i[g][k][t];
          assign mst_req_ready_o[g][k][t]   = slv_req_ready_i[Dst][k][t];
        end else begin : gen_req_fifo
          mempool_group_link_fifo #(
            .Depth (ReqDepth),
            .T     (req_t)
          ) i_req_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .in_data   (mst_req_i[g][k][t]),
            .in_valid  (mst_req_valid_i[g][k][t]),
            .in_ready  (mst_req_ready_o[g][k][t]),
            .out_data  (slv_req_o[Dst][k][t]),
            .out_valid (slv_req_valid_o[Dst][k][t]),
            .out_ready (slv_req_ready_i[Dst][k][t])
          );
        end

        if (RespDepth == 0) begin : gen_resp_wire
          assign mst_resp_o[Dst][k][t]       = slv_resp_i[g][k][t];
          assign mst_resp_valid_o[Dst][k][t] = slv_resp_valid_i[g][k][t];
          assign slv_resp_ready_o[g][k][t]   = mst_resp_ready_i[Dst][k][t];
        end else begin : gen_resp_fifo
          mempool_group_link_fifo #(
            .Depth (RespDepth),
            .T     (resp_t)
          ) i_resp_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .in_data   (slv_resp_i[g][k][t]),
            .in_valid  (slv_resp_valid_i[g][k][t]),
            .in_ready  (slv_resp_ready_o[g][k][t]),
            .out_data  (mst_resp_o[Dst][k][t]),
            .out_valid (mst_resp_valid_o[Dst][k][t]),
            .out_ready (mst_resp_ready_i[Dst][k][t])
          );
        end

      end
    end
  end

`ifdef MEMPOOL_LINK_PERF_EN
  // Per (group, direction) saturating count of cycles with any blocked request
  for (genvar g = 0; g < NumGroups; g++) begin : gen_perf_grp
    for (genvar k = 0; k < NumDirs; k++) begin : gen_perf_dir
      logic        stall;
      logic [31:0] cnt_q;

      always_comb begin
        stall = 1'b0;
        for (int unsigned t = 0; t < NumTilesPerGroup; t++) begin
          stall = stall | (mst_req_valid_i[g][k][t] & ~mst_req_ready_o[g][k][t]);
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i)             cnt_q <= '0;
        else if (stall && (cnt_q != '1))     cnt_q <= cnt_q + 32'd1;
      end

      assign stall_cnt_o[g][k] = cnt_q;
    end
  end
`else
  for (genvar g = 0; g < NumGroups; g++) begin : gen_perf_grp
    for (genvar k = 0; k < NumDirs; k++) begin : gen_perf_dir
      assign stall_cnt_o[g][k] = '0;
    end
  end
  logic perf_clr_unused;
  assign perf_clr_unused = perf_clr_i;
`endif

endmodule

// File: doc/mempool_group_link.md
# mempool_group_link

Parametrised inter-group TCDM link fabric for the MemPool cluster. It connects the remote TCDM master and slave ports of `NumGroups` groups (any power of two ≥2) over XOR-addressed directions: direction `d` from group `g` reaches group `g^d`. Every link has an independently sized elastic FIFO on both the request and response paths, which allows the cluster to be pipelined for larger group counts. Optionally, each link also has a stall-cycle performance counter.

## Interface
Parameters:
- `NumGroups`, default 4: number of groups; power of two, ≥2.
- `NumTilesPerGroup`, default 16: tiles per group; one link per tile per direction.
- `ReqDepth`, default 2: request FIFO depth per link. 0 means a combinational pass-through; 1..16 otherwise.
- `RespDepth`, default 2: response FIFO depth per link. Same range as `ReqDepth`.
- `req_t`, default `tcdm_slave_req_t`: request payload type.
- `resp_t`, default `tcdm_master_resp_t`: response payload type.
- `NumDirs`, derived as `NumGroups-1`: number of directions. Direction `d` uses index `k=d-1`.

Ports (dimension `[NumGroups][NumDirs][NumTilesPerGroup]` unless noted):
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. **One clock; reset is synchronous and active-high.**
- `mst_req_i`, in, req_t: request from group g, direction k.
- `mst_req_valid_i`, in, 1: request valid.
- `mst_req_ready_o`, out, 1: request ready.
- `mst_resp_o`, out, resp_t: response returned to group g, direction k.
- `mst_resp_valid_o`, out, 1: response valid.
- `mst_resp_ready_i`, in, 1: response ready.
- `slv_req_o`, out, req_t: request delivered to group g's slave port k.
- `slv_req_valid_o`, out, 1: request valid.
- `slv_req_ready_i`, in, 1: request ready.
- `slv_resp_i`, in, resp_t: response from group g's slave port k.
- `slv_resp_valid_i`, in, 1: response valid.
- `slv_resp_ready_o`, out, 1: response ready.
- `perf_clr_i`, in, 1: clears all stall counters.
- `stall_cnt_o`, out, `[NumGroups][NumDirs]` × 32: stall counters.

## Operation
- **Request routing:** `mst_req[g][k][t]` goes through FIFO R(g,k,t) to `slv_req[g^(k+1)][k][t]`.
- **Response routing:** `slv_resp[h][k][t]` goes through FIFO P(h,k,t) to `mst_resp[h^(k+1)][k][t]`.
- **Ordering:** none is needed. Each link is point-to-point, and order is preserved per link.
- **FIFO behaviour (Depth ≥1):**
  - Ring buffer with read/write pointers wrapping modulo Depth, plus an occupancy counter of `$clog2(Depth+1)` bits.
  - `in_ready = (count != Depth)`; `out_valid = (count != 0)`; `out_data = mem[rptr]`.
  - Push on `in_valid & in_ready`; pop on `out_valid & out_ready`.
  - Simultaneous push and pop leave the count unchanged and advance both pointers.
  - When full, no push is accepted, even if a pop happens in the same cycle. There is no fall-through path from ready to ready.
  - Payload is captured only on push. The value of `out_data` while `out_valid=0` is don't-care.
- **Depth 0:** wires only. `out = in`, `out_valid = in_valid`, `in_ready = out_ready`.
- **Handshake rules:**
  - A source must hold valid and data stable until ready.
  - The block never drops or duplicates a beat.
  - `*_ready_o` never depends combinationally on `*_valid_i` when Depth ≥1.
- **Reset:**
  - All counts, pointers and stall counters go to 0.
  - Outputs after reset: `*_valid_o=0`, `*_ready_o=1` for Depth ≥1, `stall_cnt_o=0`.
  - Asserting reset mid-transfer discards all buffered beats. Upstream must be reset concurrently.
- **Elaboration errors (`$fatal`):** `NumGroups` not a power of two or <2; any Depth >16.

## Timing
- **Latency:** Depth ≥1 gives exactly 1 cycle from accepted push to `out_valid`. Depth 0 gives 0 cycles.
- **Throughput:** Depth ≥2 sustains 1 beat/cycle per link. Depth 1 sustains 1 beat every 2 cycles.
- **Round trip through the fabric:** remote access latency increases by `ReqDepth>0` plus `RespDepth>0` cycles.
- **Stall counter:**
  - Increments by 1 each cycle in which any tile t of (g,k) has `mst_req_valid_i & !mst_req_ready_o`.
  - Saturates at `2^32-1`.
  - `perf_clr_i` takes priority and zeroes the counter on the next edge.

## Configuration
- **Macro:** `MEMPOOL_LINK_PERF_EN`.
- **Defined:** stall counters are implemented as described above.
- **Undefined:** no counter flops; `stall_cnt_o` is tied to 0 and `perf_clr_i` is ignored.

## Test plan
- **Routing:** NumGroups=4, depths 2. Drive `mst_req[0][2][5]` (d=3) with data `0xA5` for 1 cycle.
  - Expect `slv_req[3][2][5]` valid with `0xA5` exactly 1 cycle later.
  - No other slave port goes valid.
- **Backpressure/full:** hold `slv_req_ready_i[1][0][0]=0` and push 3 beats into `mst_req[0][0][0]`.
  - Beats 1–2 are accepted and `mst_req_ready_o` drops after the 2nd.
  - Release ready: beats come out in order, 1 per cycle.
  - With the perf macro on, `stall_cnt_o[0][0]` equals the number of blocked cycles.
- **Simultaneous push/pop:** at count=1, push and pop in the same cycle.
  - Count stays 1, the pointers wrap correctly over 20 beats, and data is in order.
- **Response path / NumGroups=8:** `slv_resp[6][4][3]` valid with `0x1234`.
  - Expect `mst_resp[6^5=3][4][3]` with `0x1234` 1 cycle later.
- **Depth 0:** ReqDepth=0. `slv_req_valid_o` follows `mst_req_valid_i` in the same cycle, and ready is passed straight through.
- **Reset mid-operation:** with FIFOs holding 2 beats, assert `rst_i` for 1 cycle.
  - Next cycle: all valid outputs are 0, all readies are 1, counters are 0.
